// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Arbitrates a single-port frame-buffer RAM between the display read path
//   and a small write buffer fed by the UART pixel receiver. Reads always win
//   unless the optional starvation guard forces a write.
//
//   Optional feature: define FB_STARVE_GUARD_EN to build the starvation guard
//   (forced write after STARVE_MAX consecutive full-FIFO read cycles).
//
// Ports
//   clk_sys     system clock, rising edge
//   rst_n       synchronous active-low reset
//   wr_valid    pixel push strobe            wr_data    pixel value
//   wr_ready    buffer can accept a pixel this cycle
//   rd_req      display read request         rd_addr    read address
//   rd_valid    returned pixel valid         rd_data    returned pixel
//   ram_addr    RAM address (registered)     ram_wdata  RAM write data
//   ram_we      RAM write enable             ram_q      RAM read data
//   wr_ptr      next frame write address
//   frame_done  one-cycle pulse on the write to the last pixel
//   overflow    sticky: a pixel was pushed while the buffer was full
//   rd_miss     one-cycle pulse when a read was displaced by a forced write

module fb_port_arbiter #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 3,
  parameter int unsigned MAX_PIXELS = 307200,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              frame_done,
  output logic              overflow,
  output logic              rd_miss
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------
  // Write buffer
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic [DATA_W-1:0] fifo_head;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = fifo_mem[head_q];

  // A pop in the same cycle frees a slot, so a push alongside it is accepted
  // even when full and occupancy stays constant.
  assign wr_ready = !fifo_full || pop;
  assign push     = wr_valid && wr_ready;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem[tail_q] <= wr_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail_q <= ptr_inc(tail_q);
      end
      if (pop) begin
        head_q <= ptr_inc(head_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_valid && !wr_ready) begin
      overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------
  logic starve_force;

`ifdef FB_STARVE_GUARD_EN
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  logic [STV_W-1:0] starve_q;
  logic             starve_cond;

  assign starve_cond  = fifo_full && rd_req;
  // The cycle that would be the STARVE_MAX-th consecutive starved cycle is
  // itself turned into the forced write.
  assign starve_force = starve_cond && (starve_q == STV_W'(STARVE_MAX - 1));

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      starve_q <= '0;
      rd_miss  <= 1'b0;
    end else begin
      rd_miss <= starve_force;
      if (!starve_cond || starve_force) begin
        starve_q <= '0;
      end else begin
        starve_q <= starve_q + STV_W'(1);
      end
    end
  end
`else
  assign starve_force = 1'b0;
  assign rd_miss      = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Arbitration decision
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = IDLE;
    if (starve_force) begin
      state_d = WRITE;
    end else if (rd_req) begin
      state_d = READ;
    end else if (!fifo_empty) begin
      state_d = WRITE;
    end
  end

  assign pop = (state_d == WRITE);

  // ---------------------------------------------------------------------
  // Registered RAM port, write pointer and read-return pipeline
  // ---------------------------------------------------------------------
  logic last_pixel;
  logic rd_stage2;

  assign last_pixel = (wr_ptr == ADDR_W'(MAX_PIXELS - 1));

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      wr_ptr     <= '0;
      frame_done <= 1'b0;
      rd_stage2  <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_we     <= 1'b0;
      frame_done <= 1'b0;
      case (state_d)
        READ: begin
          ram_addr <= rd_addr;
        end
        WRITE: begin
          ram_addr   <= wr_ptr;
          ram_wdata  <= fifo_head;
          ram_we     <= 1'b1;
          wr_ptr     <= last_pixel ? '0 : wr_ptr + ADDR_W'(1);
          frame_done <= last_pixel;
        end
        default: begin
        end
      endcase
      // state_q == READ marks the cycle the read address is on the RAM;
      // two more stages cover the RAM address and output registers.
      rd_stage2 <= (state_q == READ);
      rd_valid  <= rd_stage2;
    end
  end

  assign rd_data = rd_valid ? ram_q : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter
//   Scoreboard bench for fb_port_arbiter. Stimulus pushes expected RAM writes
//   and expected read returns (with the cycle they are due) into queues; a
//   monitor on the falling edge pops and compares whenever the DUT presents
//   ram_we or rd_valid. MAX_PIXELS is reduced so the frame wrap is reachable.

module tb_fb_port_arbiter;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 3;
  localparam int unsigned MAXP   = 16;

`ifdef FB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk_sys = 1'b0;
  logic              rst_n;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic              frame_done;
  logic              overflow;
  logic              rd_miss;

  fb_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_PIXELS (MAXP),
    .FIFO_DEPTH (4),
    .STARVE_MAX (8)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_q      (ram_q),
    .wr_ptr     (wr_ptr),
    .frame_done (frame_done),
    .overflow   (overflow),
    .rd_miss    (rd_miss)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // RAM model: registered address, registered output. Address 16 holds 3'b101.
  logic [DATA_W-1:0] mem [64];
  logic [ADDR_W-1:0] addr_r;
  always @(posedge clk_sys) begin
    if (cyc == 0) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[16] <= 3'b101;
    end else if (ram_we) begin
      mem[ram_addr[5:0]] <= ram_wdata;
    end
    addr_r <= ram_addr;
    ram_q  <= mem[addr_r[5:0]];
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_exp_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [31:0]       due;
  } rd_exp_t;

  wr_exp_t wq[$];
  rd_exp_t rq[$];

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int miss_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next();
    @(posedge clk_sys);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk_sys) begin
    if (ram_we === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_write_addr", 32'(ram_addr), 32'hFFFF_FFFF);
      end else begin
        wr_exp_t e;
        e = wq.pop_front();
        chk("write_addr", 32'(ram_addr), 32'(e.addr));
        chk("write_data", 32'(ram_wdata), 32'(e.data));
      end
    end
    if (rd_valid === 1'b1) begin
      if (rq.size() == 0) begin
        chk("unexpected_rd_valid", 32'(rd_data), 32'hFFFF_FFFF);
      end else begin
        rd_exp_t r;
        r = rq.pop_front();
        chk("rd_data", 32'(rd_data), 32'(r.data));
        chk("rd_latency_cycle", 32'(cyc), r.due);
      end
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      chk("frame_done_addr", 32'(ram_addr), 32'(MAXP - 1));
      chk("frame_done_we", 32'(ram_we), 32'd1);
    end
    if (rd_miss === 1'b1) miss_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_req   = 1'b0;
    rd_addr  = '0;
    repeat (3) next();

    // Reset state
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_wr_ptr", 32'(wr_ptr), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_rd_miss", 32'(rd_miss), 0);
    rst_n = 1'b1;
    next();
    chk("wr_ready_after_reset", 32'(wr_ready), 1);

    // Single read of address 0x10 -> 3'b101 three cycles later
    rd_req  = 1'b1;
    rd_addr = 19'h00010;
    rq.push_back('{data: 3'b101, due: 32'(cyc + 3)});
    next();
    rd_req = 1'b0;
    chk("read_ram_addr", 32'(ram_addr), 32'h10);
    chk("read_ram_we", 32'(ram_we), 0);
    repeat (4) next();

    // Three pixels to addresses 0,1,2
    for (int i = 1; i <= 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 3'(i);
      wq.push_back('{addr: 19'(i - 1), data: 3'(i)});
      next();
    end
    wr_valid = 1'b0;
    repeat (5) next();
    chk("wr_ptr_after_3", 32'(wr_ptr), 3);

    // Fill up to the last pixel, then the wrapping write
    for (int i = 3; i < 15; i++) begin
      wr_valid = 1'b1;
      wr_data  = 3'(i);
      wq.push_back('{addr: 19'(i), data: 3'(i)});
      next();
    end
    wr_valid = 1'b0;
    repeat (4) next();
    chk("wr_ptr_before_wrap", 32'(wr_ptr), 15);
    chk("frame_done_none_yet", 32'(fd_cnt), 0);
    wr_valid = 1'b1;
    wr_data  = 3'd7;
    wq.push_back('{addr: 19'd15, data: 3'd7});
    next();
    wr_valid = 1'b0;
    repeat (4) next();
    chk("wr_ptr_wrapped", 32'(wr_ptr), 0);
    chk("frame_done_once", 32'(fd_cnt), 1);

    // Reads held: FIFO fills, 5th push dropped, starvation window
    for (int i = 0; i < 15; i++) begin
      rd_req   = 1'b1;
      rd_addr  = 19'h00010;
      wr_valid = (i < 5);
      wr_data  = 3'(i + 1);
      if (GUARD && i == 11) begin
        wq.push_back('{addr: 19'd0, data: 3'd1});
      end else begin
        rq.push_back('{data: 3'b101, due: 32'(cyc + 3)});
      end
      #1;
      if (i == 3) chk("wr_ready_before_4th", 32'(wr_ready), 1);
      if (i == 4) chk("wr_ready_full", 32'(wr_ready), 0);
      if (i == 4) chk("overflow_before_drop", 32'(overflow), 0);
      if (i == 5) chk("overflow_set", 32'(overflow), 1);
      if (i == 12) chk("rd_miss_pulse", 32'(rd_miss), 32'(GUARD));
      if (i == 11 || i == 13) chk("rd_miss_quiet", 32'(rd_miss), 0);
      next();
    end
    rd_req   = 1'b0;
    wr_valid = 1'b0;
    if (!GUARD) wq.push_back('{addr: 19'd0, data: 3'd1});
    wq.push_back('{addr: 19'd1, data: 3'd2});
    wq.push_back('{addr: 19'd2, data: 3'd3});
    wq.push_back('{addr: 19'd3, data: 3'd4});
    repeat (8) next();
    chk("wr_ptr_after_drain", 32'(wr_ptr), 4);
    chk("overflow_sticky", 32'(overflow), 1);
    chk("miss_count", 32'(miss_cnt), 32'(GUARD));
    chk("wq_drained", 32'(wq.size()), 0);
    chk("rq_drained", 32'(rq.size()), 0);

    // Reset with 2 reads in flight and 2 buffered pixels: all discarded
    rd_req   = 1'b1;
    rd_addr  = 19'h00010;
    wr_valid = 1'b1;
    wr_data  = 3'd5;
    next();
    wr_data  = 3'd6;
    next();
    rd_req   = 1'b0;
    wr_valid = 1'b0;
    rst_n    = 1'b0;
    next();
    next();
    rst_n = 1'b1;
    next();
    chk("wr_ready_after_reset2", 32'(wr_ready), 1);
    repeat (8) next();
    chk("wr_ptr_after_reset2", 32'(wr_ptr), 0);
    chk("overflow_cleared", 32'(overflow), 0);
    chk("rd_valid_after_reset2", 32'(rd_valid), 0);
    chk("frame_done_total", 32'(fd_cnt), 1);
    chk("final_wq_empty", 32'(wq.size()), 0);
    chk("final_rq_empty", 32'(rq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
